// File: rtl/data_fetch_unit.sv
// Responder side of the CU/PE data fetch/store interface. It owns the local data memory,
// streams load rows onto the PE lanes, writes PE results back, and has a host preload/readback port.
module data_fetch_unit #(
  parameter int unsigned DW     = 32,
  parameter int unsigned NLANE  = 4,
  parameter int unsigned MEM_AW = 6
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                ADDR_START,
  input  logic                ADDR_RST,
  input  logic [3:0]          ADDRESS,
  input  logic [1:0]          PE_SEL,
  input  logic                PE_SEL_2x2,
  input  logic                PE_SEL_4,
  input  logic                WRADDR_START,
  input  logic [NLANE*DW-1:0] DATAOUT,
  output logic [NLANE*DW-1:0] DATAIN,
  output logic                DATA_VALID,
  output logic                FETCH_DONE,
  output logic                STORE_DONE,
  input  logic                HOST_WE,
  input  logic [MEM_AW-1:0]   HOST_ADDR,
  input  logic [DW-1:0]       HOST_WDATA,
  output logic [DW-1:0]       HOST_RDATA
);

  localparam int unsigned DEPTH = 2 ** MEM_AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LDONE,
    S_STORE,
    S_SDONE
  } state_t;

  logic [DW-1:0]     mem [DEPTH];
  state_t            state;
  logic [3:0]        base;
  logic [NLANE-1:0]  mask;
  logic [1:0]        elem;
  logic [1:0]        last;
  logic [DW-1:0]     snap [NLANE];

  logic [MEM_AW-1:0] cur_addr_c;
  logic              st_we_c;

  // All-lane mode beats pair mode; pair encodings 0..3 select {0,1},{2,3},{0,2},{1,3}.
  function automatic logic [NLANE-1:0] lane_mask(input logic [1:0] sel,
                                                 input logic m2, input logic m4);
    logic [NLANE-1:0] m;
    m = NLANE'(4'b0001) << sel;
    if (m4) begin
      m = '1;
    end else if (m2) begin
      case (sel)
        2'd0:    m = NLANE'(4'b0011);
        2'd1:    m = NLANE'(4'b1100);
        2'd2:    m = NLANE'(4'b0101);
        default: m = NLANE'(4'b1010);
      endcase
    end
    return m;
  endfunction

  assign cur_addr_c = MEM_AW'({base, elem});
  assign st_we_c    = (state == S_STORE) && mask[elem] && RSTN && !ADDR_RST;

  // Memory has no reset; a store write issued in the same cycle as a host write wins.
  always_ff @(posedge CLK) begin
    if (HOST_WE) mem[HOST_ADDR] <= HOST_WDATA;
    if (st_we_c) mem[cur_addr_c] <= snap[elem];
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state      <= S_IDLE;
      base       <= '0;
      mask       <= '0;
      elem       <= '0;
      last       <= '0;
      DATAIN     <= '0;
      DATA_VALID <= 1'b0;
      FETCH_DONE <= 1'b0;
      STORE_DONE <= 1'b0;
      HOST_RDATA <= '0;
      for (int i = 0; i < NLANE; i++) snap[i] <= '0;
    end else begin
      DATAIN     <= '0;
      DATA_VALID <= 1'b0;
      FETCH_DONE <= 1'b0;
      STORE_DONE <= 1'b0;
      HOST_RDATA <= mem[HOST_ADDR];
      if (ADDR_RST) begin
        state <= S_IDLE;
        elem  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            elem <= '0;
            if (ADDR_START) begin
              state <= S_LOAD;
              base  <= ADDRESS;
              mask  <= lane_mask(PE_SEL, PE_SEL_2x2, PE_SEL_4);
              last  <= PE_SEL_4 ? 2'd3 : (PE_SEL_2x2 ? 2'd1 : 2'd0);
            end else if (WRADDR_START) begin
              state <= S_STORE;
              base  <= ADDRESS;
              mask  <= lane_mask(PE_SEL, PE_SEL_2x2, PE_SEL_4);
              for (int i = 0; i < NLANE; i++) snap[i] <= DATAOUT[i*DW +: DW];
            end
          end
          S_LOAD: begin
            DATA_VALID <= 1'b1;
            for (int i = 0; i < NLANE; i++)
              DATAIN[i*DW +: DW] <= mask[i] ? mem[cur_addr_c] : '0;
            elem <= elem + 2'd1;
            if (elem == last) begin
              state <= S_LDONE;
              elem  <= '0;
            end
          end
          S_LDONE: begin
            FETCH_DONE <= 1'b1;
            state      <= S_IDLE;
          end
          // Every lane slot takes a cycle, masked or not.
          S_STORE: begin
            elem <= elem + 2'd1;
            if (elem == 2'd3) begin
              state      <= S_SDONE;
              STORE_DONE <= 1'b1;
              elem       <= '0;
            end
          end
          S_SDONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_fetch_unit.sv
// Directed bench for data_fetch_unit: loads in each lane mode, masked store, abort and reset.
module tb_data_fetch_unit;
  localparam int unsigned DW = 32;
  localparam int unsigned NLANE = 4;
  localparam int unsigned MEM_AW = 6;

  logic                CLK = 1'b0;
  logic                RSTN;
  logic                ADDR_START, ADDR_RST, PE_SEL_2x2, PE_SEL_4, WRADDR_START;
  logic [3:0]          ADDRESS;
  logic [1:0]          PE_SEL;
  logic [NLANE*DW-1:0] DATAOUT, DATAIN;
  logic                DATA_VALID, FETCH_DONE, STORE_DONE, HOST_WE;
  logic [MEM_AW-1:0]   HOST_ADDR;
  logic [DW-1:0]       HOST_WDATA, HOST_RDATA;

  int n_vec = 0;
  int n_err = 0;

  data_fetch_unit #(.DW(DW), .NLANE(NLANE), .MEM_AW(MEM_AW)) dut (
    .CLK(CLK), .RSTN(RSTN), .ADDR_START(ADDR_START), .ADDR_RST(ADDR_RST),
    .ADDRESS(ADDRESS), .PE_SEL(PE_SEL), .PE_SEL_2x2(PE_SEL_2x2), .PE_SEL_4(PE_SEL_4),
    .WRADDR_START(WRADDR_START), .DATAOUT(DATAOUT), .DATAIN(DATAIN),
    .DATA_VALID(DATA_VALID), .FETCH_DONE(FETCH_DONE), .STORE_DONE(STORE_DONE),
    .HOST_WE(HOST_WE), .HOST_ADDR(HOST_ADDR), .HOST_WDATA(HOST_WDATA), .HOST_RDATA(HOST_RDATA)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [NLANE*DW-1:0] obs, input logic [NLANE*DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NLANE*DW-1:0] lanes(input int l3, input int l2, input int l1, input int l0);
    return {DW'(l3), DW'(l2), DW'(l1), DW'(l0)};
  endfunction

  task automatic hwrite(input int a, input int d);
    HOST_WE = 1'b1; HOST_ADDR = MEM_AW'(a); HOST_WDATA = DW'(d);
    tick();
    HOST_WE = 1'b0;
  endtask

  task automatic hread(input string tag, input int a, input int exp);
    HOST_ADDR = MEM_AW'(a);
    tick();
    chk(tag, {96'd0, HOST_RDATA}, {96'd0, DW'(exp)});
  endtask

  // Drives a request during the current cycle T and returns in cycle T+1.
  task automatic req(input logic ld, input logic st, input int addr, input int sel,
                     input logic m2, input logic m4);
    ADDR_START = ld; WRADDR_START = st; ADDRESS = 4'(addr); PE_SEL = 2'(sel);
    PE_SEL_2x2 = m2; PE_SEL_4 = m4;
    tick();
    ADDR_START = 1'b0; WRADDR_START = 1'b0;
  endtask

  initial begin
    RSTN = 1'b0; ADDR_START = 1'b0; ADDR_RST = 1'b0; ADDRESS = '0; PE_SEL = '0;
    PE_SEL_2x2 = 1'b0; PE_SEL_4 = 1'b0; WRADDR_START = 1'b0; DATAOUT = '0;
    HOST_WE = 1'b0; HOST_ADDR = '0; HOST_WDATA = '0;
    tick(); tick();
    chk("rst_valid", {127'd0, DATA_VALID}, '0);
    chk("rst_datain", DATAIN, '0);
    chk("rst_fdone", {127'd0, FETCH_DONE}, '0);
    chk("rst_sdone", {127'd0, STORE_DONE}, '0);
    chk("rst_hrdata", {96'd0, HOST_RDATA}, '0);
    RSTN = 1'b1;

    hwrite(8, 23); hwrite(9, 63); hwrite(10, 5); hwrite(11, 6);
    hwrite(60, 1); hwrite(61, 2); hwrite(62, 3); hwrite(63, 4);
    hwrite(4, 100); hwrite(5, 101); hwrite(6, 102); hwrite(7, 103);

    // Pair 0 load
    req(1'b1, 1'b0, 2, 0, 1'b1, 1'b0);
    chk("p0_t1_valid", {127'd0, DATA_VALID}, '0);
    tick();
    chk("p0_t2_data", DATAIN, lanes(0, 0, 23, 23));
    chk("p0_t2_valid", {127'd0, DATA_VALID}, 128'd1);
    tick();
    chk("p0_t3_data", DATAIN, lanes(0, 0, 63, 63));
    chk("p0_t3_fdone", {127'd0, FETCH_DONE}, '0);
    tick();
    chk("p0_t4_fdone", {127'd0, FETCH_DONE}, 128'd1);
    chk("p0_t4_valid", {127'd0, DATA_VALID}, '0);
    chk("p0_t4_data", DATAIN, '0);

    // Pair 1 and pair 3
    req(1'b1, 1'b0, 2, 1, 1'b1, 1'b0);
    tick(); chk("p1_t2_data", DATAIN, lanes(23, 23, 0, 0));
    tick(); chk("p1_t3_data", DATAIN, lanes(63, 63, 0, 0));
    tick(); chk("p1_t4_fdone", {127'd0, FETCH_DONE}, 128'd1);
    req(1'b1, 1'b0, 2, 3, 1'b1, 1'b0);
    tick(); chk("p3_t2_data", DATAIN, lanes(23, 0, 23, 0));
    tick(); chk("p3_t3_data", DATAIN, lanes(63, 0, 63, 0));
    tick(); chk("p3_t4_fdone", {127'd0, FETCH_DONE}, 128'd1);

    // All-lane load at top row; PE_SEL_4 must override PE_SEL_2x2
    req(1'b1, 1'b0, 15, 0, 1'b1, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("all_data", DATAIN, lanes(k, k, k, k));
      chk("all_valid", {127'd0, DATA_VALID}, 128'd1);
    end
    chk("all_t5_fdone", {127'd0, FETCH_DONE}, '0);
    tick();
    chk("all_t6_fdone", {127'd0, FETCH_DONE}, 128'd1);
    chk("all_t6_valid", {127'd0, DATA_VALID}, '0);

    // Single-lane load
    req(1'b1, 1'b0, 15, 2, 1'b0, 1'b0);
    tick(); chk("one_t2_data", DATAIN, lanes(0, 1, 0, 0));
    tick(); chk("one_t3_fdone", {127'd0, FETCH_DONE}, 128'd1);
    chk("one_t3_valid", {127'd0, DATA_VALID}, '0);

    // Masked store of lanes 0,2 with DATAOUT changing after the request
    DATAOUT = lanes(44, 33, 22, 11);
    req(1'b0, 1'b1, 1, 2, 1'b1, 1'b0);
    DATAOUT = lanes(99, 99, 99, 99);
    tick(); tick(); tick();
    chk("st_t4_sdone", {127'd0, STORE_DONE}, '0);
    tick();
    chk("st_t5_sdone", {127'd0, STORE_DONE}, 128'd1);
    tick();
    chk("st_t6_sdone", {127'd0, STORE_DONE}, '0);
    hread("st_mem4", 4, 11);
    hread("st_mem5", 5, 101);
    hread("st_mem6", 6, 33);
    hread("st_mem7", 7, 103);

    // Simultaneous load and store: load only
    DATAOUT = lanes(9, 9, 9, 9);
    req(1'b1, 1'b1, 2, 0, 1'b0, 1'b1);
    tick(); chk("both_t2_data", DATAIN, lanes(23, 23, 23, 23));
    tick(); chk("both_t3_data", DATAIN, lanes(63, 63, 63, 63));
    tick(); chk("both_t4_data", DATAIN, lanes(5, 5, 5, 5));
    tick(); chk("both_t5_data", DATAIN, lanes(6, 6, 6, 6));
    tick(); chk("both_t6_fdone", {127'd0, FETCH_DONE}, 128'd1);
    chk("both_t6_sdone", {127'd0, STORE_DONE}, '0);
    tick(); tick(); tick();
    chk("both_no_sdone", {127'd0, STORE_DONE}, '0);
    hread("both_mem8", 8, 23);
    hread("both_mem11", 11, 6);

    // Abort a 4-element load at T+3, new single-lane request at T+4
    req(1'b1, 1'b0, 15, 0, 1'b0, 1'b1);
    tick(); chk("ab_t2_data", DATAIN, lanes(1, 1, 1, 1));
    tick(); chk("ab_t3_data", DATAIN, lanes(2, 2, 2, 2));
    ADDR_RST = 1'b1;
    tick();
    ADDR_RST = 1'b0;
    chk("ab_t4_valid", {127'd0, DATA_VALID}, '0);
    chk("ab_t4_data", DATAIN, '0);
    req(1'b1, 1'b0, 2, 1, 1'b0, 1'b0);
    chk("ab_t5_fdone", {127'd0, FETCH_DONE}, '0);
    chk("ab_t5_valid", {127'd0, DATA_VALID}, '0);
    tick();
    chk("ab_t6_data", DATAIN, lanes(0, 0, 23, 0));
    chk("ab_t6_fdone", {127'd0, FETCH_DONE}, '0);
    tick();
    chk("ab_t7_fdone", {127'd0, FETCH_DONE}, 128'd1);

    // Reset in the middle of a load; memory retained
    req(1'b1, 1'b0, 15, 0, 1'b0, 1'b1);
    tick();
    chk("rl_t2_valid", {127'd0, DATA_VALID}, 128'd1);
    RSTN = 1'b0;
    tick();
    chk("rl_valid", {127'd0, DATA_VALID}, '0);
    chk("rl_data", DATAIN, '0);
    tick();
    RSTN = 1'b1;
    tick(); tick(); tick();
    chk("rl_post_valid", {127'd0, DATA_VALID}, '0);
    chk("rl_post_fdone", {127'd0, FETCH_DONE}, '0);
    hread("rl_mem61", 61, 2);
    hread("rl_mem6", 6, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
